hyperram_responder: RTL and testbench

HyperBus responder (device side) for the HyperRAM controller: decodes the 48-bit command/address, applies the initial latency, and serves read and write bursts from an internal word array plus one configuration register. It sits on the `dq`/`rwds`/`ckout`/`csn`/`rstn` pins of the controller in simulation and FPGA loopback builds, standing in for the external HyperRAM. All logic runs on `clk_clk`, at 2× the HyperBus CK frequency or faster. Each CK transition is detected as one DDR edge.

---
 rtl/hyperram_responder_if.sv | 24 ++
 rtl/hyperram_responder.sv | 187 ++++++++++++++++++
 tb/tb_hyperram_responder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/hyperram_responder_if.sv
// HyperBus pin bundle between a HyperRAM controller (master) and a device model (slave).
// Latency: none, plain wires.
// Backpressure: none; the controller paces every transfer with CK.
interface hyperram_responder_if;
  logic       rstn;
  logic       csn;
  logic       ck;
  logic [7:0] dq_in;
  logic [7:0] dq_out;
  logic       dq_oe;
  logic       rwds_in;
  logic       rwds_out;
  logic       rwds_oe;

  modport master (
    output rstn, csn, ck, dq_in, rwds_in,
    input  dq_out, dq_oe, rwds_out, rwds_oe
  );

  modport slave (
    input  rstn, csn, ck, dq_in, rwds_in,
    output dq_out, dq_oe, rwds_out, rwds_oe
  );
endinterface

// File: rtl/hyperram_responder.sv
// HyperRAM device model: decodes CA, applies initial latency, serves bursts from a word array and CR0.
// Latency: CK edges seen 1 clk after they occur; read byte registered 1 clk after its edge is seen.
// Backpressure: none; the controller owns CK and csn, and the responder follows every edge.
module hyperram_responder #(
  parameter int ADDR_W   = 10,
  parameter int LATENCY  = 6,
  parameter int FIXED_2X = 1
) (
  input logic                  clk_clk,
  input logic                  reset_reset_n,
  hyperram_responder_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CA, LAT, RD, WR} state_t;

  localparam int          LAT_EDGES = 2 * LATENCY * ((FIXED_2X != 0) ? 2 : 1);
  localparam logic [15:0] CR0_RST   = 16'h8F1F;

  state_t              state_q, state_d;
  logic                ck_q;
  logic [39:0]         ca_q, ca_d;
  logic [2:0]          ca_cnt_q, ca_cnt_d;
  logic [7:0]          lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                is_rd_q, is_rd_d;
  logic                is_reg_q, is_reg_d;
  logic                is_lin_q, is_lin_d;
  logic [15:0]         cr0_q, cr0_d;
  logic [7:0]          dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;
  logic                rwds_out_q, rwds_out_d;
  logic                rwds_oe_q, rwds_oe_d;

  logic [15:0]         mem [2**ADDR_W];
  logic                mem_we_hi, mem_we_lo;

  logic                ck_edge, ck_rise;
  logic [47:0]         ca_full;
  logic [15:0]         rd_word;
  logic [ADDR_W-1:0]   addr_nxt;

  assign bus.dq_out   = dq_out_q;
  assign bus.dq_oe    = dq_oe_q;
  assign bus.rwds_out = rwds_out_q;
  assign bus.rwds_oe  = rwds_oe_q;

  // Next-state, counters, write strobes and registered pin values.
  always_comb begin
    state_d    = state_q;
    ca_d       = ca_q;
    ca_cnt_d   = ca_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    addr_d     = addr_q;
    is_rd_d    = is_rd_q;
    is_reg_d   = is_reg_q;
    is_lin_d   = is_lin_q;
    cr0_d      = cr0_q;
    dq_out_d   = dq_out_q;
    rwds_out_d = rwds_out_q;
    mem_we_hi  = 1'b0;
    mem_we_lo  = 1'b0;

    // Each CK transition is one DDR edge; edges outside chip select are ignored.
    ck_edge  = (bus.ck != ck_q) & ~bus.csn;
    ck_rise  = ck_edge & bus.ck;
    ca_full  = {ca_q, bus.dq_in};
    rd_word  = is_reg_q ? cr0_q : mem[addr_q];
    // Wrapped bursts stay inside a 16-word (32-byte) aligned group.
    addr_nxt = is_lin_q ? addr_q + 1'b1 : {addr_q[ADDR_W-1:4], addr_q[3:0] + 4'd1};

    unique case (state_q)
      IDLE: begin
        if (!bus.csn) begin
          state_d  = CA;
          ca_cnt_d = 3'd0;
        end
      end
      CA: begin
        if (ck_edge) begin
          ca_d     = ca_full[39:0];
          ca_cnt_d = ca_cnt_q + 3'd1;
          if (ca_cnt_q == 3'd5) begin
            is_rd_d  = ca_full[47];
            is_reg_d = ca_full[46];
            is_lin_d = ca_full[45];
            addr_d   = ADDR_W'({ca_full[44:16], ca_full[2:0]});
            // Register writes carry no latency; everything else waits.
            if (!ca_full[47] && ca_full[46]) begin
              state_d = WR;
            end else begin
              state_d   = LAT;
              lat_cnt_d = 8'(LAT_EDGES);
            end
          end
        end
      end
      LAT: begin
        if (ck_edge) begin
          lat_cnt_d = lat_cnt_q - 8'd1;
          if (lat_cnt_q == 8'd1) state_d = is_rd_q ? RD : WR;
        end
      end
      RD: begin
        if (ck_edge) begin
          if (ck_rise) begin
            dq_out_d   = rd_word[15:8];
            rwds_out_d = 1'b1;
          end else begin
            dq_out_d   = rd_word[7:0];
            rwds_out_d = 1'b0;
            addr_d     = addr_nxt;
          end
        end
      end
      WR: begin
        if (ck_edge) begin
          if (is_reg_q) begin
            if (ck_rise) cr0_d[15:8] = bus.dq_in;
            else         cr0_d[7:0]  = bus.dq_in;
          end else if (!bus.rwds_in) begin
            mem_we_hi = ck_rise;
            mem_we_lo = ~ck_rise;
          end
          if (!ck_rise) addr_d = addr_nxt;
        end
      end
      default: state_d = IDLE;
    endcase

    // Chip deselect or device reset aborts any burst; written bytes are kept.
    if (bus.csn || !bus.rstn) state_d = IDLE;
    if (!bus.rstn)            cr0_d   = CR0_RST;

    unique case (state_d)
      IDLE:    begin dq_out_d = 8'd0; rwds_out_d = 1'b0; end
      CA:      rwds_out_d = (FIXED_2X != 0);
      LAT:     rwds_out_d = 1'b0;
      WR:      rwds_out_d = 1'b0;
      default: ;
    endcase

    dq_oe_d   = (state_d == RD);
    rwds_oe_d = (state_d == CA) || (state_d == RD) || ((state_d == LAT) && is_rd_d);
  end

  // Control state and registered pin drivers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= IDLE;
      ck_q       <= 1'b0;
      ca_q       <= '0;
      ca_cnt_q   <= 3'd0;
      lat_cnt_q  <= 8'd0;
      addr_q     <= '0;
      is_rd_q    <= 1'b0;
      is_reg_q   <= 1'b0;
      is_lin_q   <= 1'b0;
      cr0_q      <= CR0_RST;
      dq_out_q   <= 8'd0;
      dq_oe_q    <= 1'b0;
      rwds_out_q <= 1'b0;
      rwds_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ck_q       <= bus.ck;
      ca_q       <= ca_d;
      ca_cnt_q   <= ca_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      addr_q     <= addr_d;
      is_rd_q    <= is_rd_d;
      is_reg_q   <= is_reg_d;
      is_lin_q   <= is_lin_d;
      cr0_q      <= cr0_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      rwds_out_q <= rwds_out_d;
      rwds_oe_q  <= rwds_oe_d;
    end
  end

  // Word array: byte-granular writes, contents deliberately not reset.
  always_ff @(posedge clk_clk) begin
    if (mem_we_hi) mem[addr_q][15:8] <= bus.dq_in;
    if (mem_we_lo) mem[addr_q][7:0]  <= bus.dq_in;
  end

endmodule

// File: tb/tb_hyperram_responder.sv
module tb_hyperram_responder;
  logic clk_clk       = 1'b0;
  logic reset_reset_n = 1'b0;
  int   checks        = 0;
  int   errors        = 0;

  hyperram_responder_if bus();

  hyperram_responder #(.ADDR_W(10), .LATENCY(6), .FIXED_2X(1)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .bus           (bus)
  );

  always #5 clk_clk = ~clk_clk;

  localparam int LATE = 24; // 2 * LATENCY * 2 for double latency

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One CK transition with data/mask; returns the pins one clk after the edge is seen.
  task automatic do_edge(input logic [7:0] d, input logic m,
                         output logic [7:0] q, output logic r, output logic oe);
    @(negedge clk_clk);
    bus.ck      = ~bus.ck;
    bus.dq_in   = d;
    bus.rwds_in = m;
    @(negedge clk_clk);
    q  = bus.dq_out;
    r  = bus.rwds_out;
    oe = bus.dq_oe;
  endtask

  task automatic start_ca(input logic rd, input logic reg_sp, input logic lin,
                          input logic [31:0] addr, input logic chk);
    logic [47:0] ca;
    logic [7:0]  q;
    logic        r, oe;
    ca = {rd, reg_sp, lin, addr[31:3], 13'd0, addr[2:0]};
    @(negedge clk_clk);
    bus.csn = 1'b0;
    @(negedge clk_clk);
    if (chk) check("ca_rwds_pre", {bus.rwds_oe, bus.rwds_out}, 2'b11);
    for (int i = 0; i < 6; i++) begin
      do_edge(ca[47-8*i -: 8], 1'b0, q, r, oe);
      if (chk && i < 5) check("ca_rwds", {bus.rwds_oe, r}, 2'b11);
    end
    if (chk) check("ca_rwds_after6", {bus.rwds_oe, bus.rwds_out}, rd ? 2'b10 : 2'b00);
  endtask

  task automatic lat_edges(input int n);
    logic [7:0] q;
    logic       r, oe;
    for (int i = 0; i < n; i++) do_edge(8'h00, 1'b0, q, r, oe);
  endtask

  task automatic end_txn();
    @(negedge clk_clk);
    bus.csn = 1'b1;
    bus.ck  = 1'b0;
    @(negedge clk_clk);
    @(negedge clk_clk);
  endtask

  task automatic wr_word(input logic [15:0] w, input logic mhi, input logic mlo);
    logic [7:0] q;
    logic       r, oe;
    do_edge(w[15:8], mhi, q, r, oe);
    do_edge(w[7:0],  mlo, q, r, oe);
  endtask

  task automatic rd_word(input string tag, input logic [15:0] exp);
    logic [7:0] hi, lo;
    logic       rhi, rlo, oe_hi, oe_lo;
    do_edge(8'h00, 1'b0, hi, rhi, oe_hi);
    do_edge(8'h00, 1'b0, lo, rlo, oe_lo);
    check(tag, {rhi, rlo, oe_hi, oe_lo, hi, lo}, {4'b1011, exp});
  endtask

  initial begin
    logic [7:0] q;
    logic       r, oe;

    bus.rstn    = 1'b1;
    bus.csn     = 1'b1;
    bus.ck      = 1'b0;
    bus.dq_in   = 8'h00;
    bus.rwds_in = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_clk);
    check("reset_outputs", {bus.dq_out, bus.dq_oe, bus.rwds_out, bus.rwds_oe}, 11'd0);
    reset_reset_n = 1'b1;
    repeat (2) @(negedge clk_clk);
    check("idle_outputs", {bus.dq_out, bus.dq_oe, bus.rwds_out, bus.rwds_oe}, 11'd0);

    // Register read after reset
    start_ca(1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
    lat_edges(LATE);
    rd_word("cr0_reset", 16'h8F1F);
    end_txn();

    // Linear memory write then read
    start_ca(1'b0, 1'b0, 1'b1, 32'h010, 1'b1);
    lat_edges(LATE);
    wr_word(16'h1234, 1'b0, 1'b0);
    wr_word(16'h5678, 1'b0, 1'b0);
    wr_word(16'h9ABC, 1'b0, 1'b0);
    wr_word(16'hDEF0, 1'b0, 1'b0);
    end_txn();
    start_ca(1'b1, 1'b0, 1'b1, 32'h010, 1'b1);
    lat_edges(LATE);
    rd_word("lin_rd0", 16'h1234);
    rd_word("lin_rd1", 16'h5678);
    rd_word("lin_rd2", 16'h9ABC);
    rd_word("lin_rd3", 16'hDEF0);
    end_txn();

    // Masked write: upper byte masked
    start_ca(1'b0, 1'b0, 1'b1, 32'h020, 1'b0);
    lat_edges(LATE);
    wr_word(16'h1111, 1'b0, 1'b0);
    end_txn();
    start_ca(1'b0, 1'b0, 1'b1, 32'h020, 1'b0);
    lat_edges(LATE);
    wr_word(16'hAAAA, 1'b1, 1'b0);
    end_txn();
    start_ca(1'b1, 1'b0, 1'b1, 32'h020, 1'b0);
    lat_edges(LATE);
    rd_word("masked_rd", 16'h11AA);
    end_txn();

    // Wrapped read across the 16-word boundary
    start_ca(1'b0, 1'b0, 1'b1, 32'h030, 1'b0);
    lat_edges(LATE);
    for (int i = 0; i < 16; i++) wr_word(16'h0030 + 16'(i), 1'b0, 1'b0);
    end_txn();
    start_ca(1'b1, 1'b0, 1'b0, 32'h03E, 1'b0);
    lat_edges(LATE);
    rd_word("wrap_rd0", 16'h003E);
    rd_word("wrap_rd1", 16'h003F);
    rd_word("wrap_rd2", 16'h0030);
    rd_word("wrap_rd3", 16'h0031);
    end_txn();

    // Abort a write after three bytes
    start_ca(1'b0, 1'b0, 1'b1, 32'h041, 1'b0);
    lat_edges(LATE);
    wr_word(16'h5A5A, 1'b0, 1'b0);
    end_txn();
    start_ca(1'b0, 1'b0, 1'b1, 32'h040, 1'b0);
    lat_edges(LATE);
    wr_word(16'hCAFE, 1'b0, 1'b0);
    do_edge(8'hBE, 1'b0, q, r, oe);
    @(negedge clk_clk);
    bus.csn = 1'b1;
    bus.ck  = 1'b0;
    @(negedge clk_clk);
    check("abort_wr_oe", {bus.dq_oe, bus.rwds_oe}, 2'b00);
    @(negedge clk_clk);

    // Abort a read mid-burst
    start_ca(1'b1, 1'b0, 1'b1, 32'h010, 1'b0);
    lat_edges(LATE);
    do_edge(8'h00, 1'b0, q, r, oe);
    check("abort_rd_pre", {oe, bus.rwds_oe, r, q}, {3'b111, 8'h12});
    @(negedge clk_clk);
    bus.csn = 1'b1;
    bus.ck  = 1'b0;
    @(negedge clk_clk);
    check("abort_rd_oe", {bus.dq_oe, bus.rwds_oe}, 2'b00);
    @(negedge clk_clk);

    start_ca(1'b1, 1'b0, 1'b1, 32'h040, 1'b0);
    lat_edges(LATE);
    rd_word("abort_w40", 16'hCAFE);
    rd_word("abort_w41", 16'hBE5A);
    end_txn();

    // Register write at zero latency, then device reset
    start_ca(1'b0, 1'b1, 1'b1, 32'h0, 1'b0);
    wr_word(16'h8F17, 1'b0, 1'b0);
    end_txn();
    start_ca(1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
    lat_edges(LATE);
    rd_word("cr0_written", 16'h8F17);
    end_txn();

    @(negedge clk_clk);
    bus.rstn = 1'b0;
    repeat (3) @(negedge clk_clk);
    bus.rstn = 1'b1;
    @(negedge clk_clk);

    start_ca(1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
    lat_edges(LATE);
    rd_word("cr0_after_rstn", 16'h8F1F);
    end_txn();
    start_ca(1'b1, 1'b0, 1'b1, 32'h010, 1'b0);
    lat_edges(LATE);
    rd_word("array_after_rstn0", 16'h1234);
    rd_word("array_after_rstn1", 16'h5678);
    end_txn();
    start_ca(1'b1, 1'b0, 1'b1, 32'h020, 1'b0);
    lat_edges(LATE);
    rd_word("array_after_rstn2", 16'h11AA);
    end_txn();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
